// File: rtl/snitch_icache_pkg.sv
// Shared types and constants for the icache refill path.
// The top module declares its own beat struct at its FILL_DW; refill_beat_t is the default-width form.
package snitch_icache_pkg;

    localparam int unsigned REFILL_LEN_W      = 8;
    localparam int unsigned REFILL_DW_DEFAULT = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } refill_state_e;

    typedef struct packed {
        logic [REFILL_DW_DEFAULT-1:0] data;
        logic                         error;
        logic                         last;
    } refill_beat_t;

    // Number of byte-offset bits inside one beat of width dw bits.
    function automatic int unsigned beat_offset(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with optional fall-through, pointer-based storage.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en;
    logic                  testmode_unused;

    assign testmode_unused = testmode_i;
    assign full_o          = (cnt_q == FULL_CNT);
    assign usage_o         = cnt_q[ADDR_DEPTH-1:0];

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        data_o   = mem_q[rd_ptr_q];
        empty_o  = (cnt_q == '0);

        if (push_i && !full_o) begin
            wr_en    = 1'b1;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            cnt_d    = cnt_d + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            cnt_d    = cnt_d - 1'b1;
        end
        // Bypass: an empty fall-through FIFO presents the incoming word directly.
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o  = data_i;
            empty_o = 1'b0;
            if (pop_i) begin
                wr_en    = 1'b0;
                wr_ptr_d = wr_ptr_q;
                cnt_d    = cnt_q;
            end
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            wr_en    = 1'b0;
        end
    end

    // NOTE: storage is reset as well so the read port shows zero, not X, straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (wr_en) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/snitch_icache_refill_responder.sv
// Memory-side responder for icache refills: one burst at a time, reads pipelined
// against a credit limit so the response buffer can never overflow.
module snitch_icache_refill_responder
    import snitch_icache_pkg::*;
#(
    parameter int unsigned FILL_AW   = 32,
    parameter int unsigned FILL_DW   = 64,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [FILL_AW-1:0]      refill_qaddr_i,
    input  logic [REFILL_LEN_W-1:0] refill_qlen_i,
    input  logic                    refill_qvalid_i,
    output logic                    refill_qready_o,
    output logic [FILL_DW-1:0]      refill_pdata_o,
    output logic                    refill_perror_o,
    output logic                    refill_plast_o,
    output logic                    refill_pvalid_o,
    input  logic                    refill_pready_i,
    output logic                    mem_req_o,
    output logic [FILL_AW-1:0]      mem_addr_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [FILL_DW-1:0]      mem_rdata_i,
    input  logic                    mem_rerror_i
);

    localparam int unsigned OFFS_W = beat_offset(FILL_DW);
    localparam int unsigned CNT_W  = REFILL_LEN_W + 1;
    localparam int unsigned BUF_AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [FILL_AW-1:0] ADDR_MASK = ~((FILL_AW'(1) << OFFS_W) - FILL_AW'(1));

    typedef struct packed {
        logic [FILL_DW-1:0] data;
        logic               error;
        logic               last;
    } beat_t;

    refill_state_e             state_q, state_d;
    logic [FILL_AW-1:0]        base_q, base_d;
    logic [REFILL_LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]          issued_q, issued_d;
    logic [CNT_W-1:0]          received_q, received_d;
    logic [CNT_W-1:0]          sent_q, sent_d;
    logic [CNT_W-1:0]          len_ext, inflight, occupancy, credit_used, buf_occ;
    logic                      buf_full, buf_empty, buf_push, buf_pop;
    logic [BUF_AW-1:0]         buf_usage;
    beat_t                     push_beat, head_beat;

    assign len_ext     = {1'b0, len_q};
    assign inflight    = issued_q - received_q;
    assign occupancy   = received_q - sent_q;
    // Every granted read holds one buffer slot until its beat leaves the buffer.
    assign credit_used = inflight + occupancy;

    assign refill_pvalid_o = ~buf_empty;
    assign refill_pdata_o  = head_beat.data;
    assign refill_perror_o = head_beat.error;
    assign refill_plast_o  = head_beat.last;
    assign buf_pop         = refill_pvalid_o & refill_pready_i;
    assign push_beat       = '{data: mem_rdata_i, error: mem_rerror_i, last: (received_q == len_ext)};

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        len_d           = len_q;
        issued_d        = issued_q;
        received_d      = received_q;
        sent_d          = sent_q;
        refill_qready_o = 1'b0;
        mem_req_o       = 1'b0;
        mem_addr_o      = '0;
        buf_push        = 1'b0;

        unique case (state_q)
            IDLE: begin
                refill_qready_o = 1'b1;
                if (refill_qvalid_i) begin
                    base_d     = refill_qaddr_i & ADDR_MASK;
                    len_d      = refill_qlen_i;
                    issued_d   = '0;
                    received_d = '0;
                    sent_d     = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                mem_req_o  = (issued_q <= len_ext) && (credit_used < CNT_W'(RSP_DEPTH));
                mem_addr_o = base_q + (FILL_AW'(issued_q) << OFFS_W);
                if (mem_req_o && mem_gnt_i) issued_d = issued_q + 1'b1;
                if (mem_rvalid_i) begin
                    buf_push   = 1'b1;
                    received_d = received_q + 1'b1;
                end
                if (buf_pop) begin
                    sent_d = sent_q + 1'b1;
                    if (head_beat.last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            sent_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            sent_q     <= sent_d;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (FILL_DW + 2),
        .DEPTH        (RSP_DEPTH)
    ) i_rsp_buf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .usage_o    (buf_usage),
        .data_i     (push_beat),
        .push_i     (buf_push),
        .data_o     (head_beat),
        .pop_i      (buf_pop)
    );

    assign buf_occ = buf_full ? CNT_W'(RSP_DEPTH) : CNT_W'(buf_usage);

    assert property (@(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> (inflight != '0))
        else $error("mem_rvalid_i with no read in flight");

    assert property (@(posedge clk_i) disable iff (!rst_ni) buf_occ == occupancy)
        else $error("response buffer occupancy out of step with beat counters");

endmodule
